arcade_input_cond: RTL and testbench

Frame-synchronous player-input conditioner sitting between the HPS joystick words and the game core's control inputs (start, coin, direction, fire). It debounces raw joystick bits and maps both pads onto player 1/player 2 according to cabinet mode. It removes impossible opposite-direction combinations and latches directions/fire once per frame at vblank. It also turns a coin press into a fixed-length, rate-limited coin pulse the game CPU cannot miss.

---
 rtl/arcade_input_pkg.sv | 42 ++++
 rtl/arcade_input_cond_if.sv | 29 ++
 rtl/input_debounce.sv | 47 ++++
 rtl/arcade_input_cond.sv | 152 +++++++++++++++
 tb/tb_arcade_input_cond.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants, coin FSM state type and SOCD helper for the arcade input conditioner.
package arcade_input_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // Raw vector: P1 dir/fire in [4:0], P2 dir/fire in [9:5], then start1, start2, coin.
  localparam int RAW_P1_LSB = 0;
  localparam int RAW_P2_LSB = 5;
  localparam int RAW_START1 = 10;
  localparam int RAW_START2 = 11;
  localparam int RAW_COIN   = 12;
  localparam int RAW_W      = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Opposite directions pressed together cancel each other out.
  function automatic logic [4:0] socd_clean(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    if (v[JOY_UP] && v[JOY_DOWN]) begin
      r[JOY_UP]   = 1'b0;
      r[JOY_DOWN] = 1'b0;
    end
    if (v[JOY_LEFT] && v[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b0;
      r[JOY_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_cond_if.sv
// Joystick words in, conditioned player controls out, grouped as one bundle.
interface arcade_input_cond_if;
  import arcade_input_pkg::*;

  // No handshake: every signal is a level, sampled by the conditioner on each
  // clk_sys edge; there is no valid/ready pairing and no back-pressure.
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        cocktail;
  logic        vblank;
  logic        up1, down1, left1, right1, fire1;
  logic        up2, down2, left2, right2, fire2;
  logic        start1, start2;
  logic        coin1;

  modport master (
    output joystick_0, joystick_1, cocktail, vblank,
    input  up1, down1, left1, right1, fire1,
    input  up2, down2, left2, right2, fire2,
    input  start1, start2, coin1
  );

  modport slave (
    input  joystick_0, joystick_1, cocktail, vblank,
    output up1, down1, left1, right1, fire1,
    output up2, down2, left2, right2, fire2,
    output start1, start2, coin1
  );
endinterface

// File: rtl/input_debounce.sv
// Sampled debouncer: a bit only changes after two consecutive equal samples, one per tick.
module input_debounce #(
  parameter int WIDTH    = 13,
  parameter int DEB_TICK = 12000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] deb
);

  localparam int CW = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DEB_TICK - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] stable;
  logic             tick;

  always_comb begin
    tick   = (cnt_q == TICK_LAST);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    stable = ~(raw ^ samp_q);
    samp_d = samp_q;
    deb_d  = deb_q;
    if (tick) begin
      samp_d = raw;
      deb_d  = (raw & stable) | (deb_q & ~stable);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      samp_q <= '0;
      deb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Pad mapping, debounce, SOCD cleanup, vblank frame latch and rate-limited coin pulse shaping.
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int DEB_TICK    = 12000,
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 6
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  arcade_input_cond_if.slave  io,
  output coin_state_t         coin_state_dbg
);

  localparam logic [3:0] CF = 4'(COIN_FRAMES);
  localparam logic [3:0] CG = 4'(COIN_GAP);

  logic [7:0]       pad_or;
  logic [4:0]       p1_src, p2_src;
  logic [RAW_W-1:0] raw, deb;
  logic             unused_hi;

  // Cocktail selects per-pad players; otherwise both players see either pad.
  always_comb begin
    pad_or = io.joystick_0[7:0] | io.joystick_1[7:0];
    p1_src = io.cocktail ? io.joystick_0[4:0] : pad_or[4:0];
    p2_src = io.cocktail ? io.joystick_1[4:0] : pad_or[4:0];
    raw                   = '0;
    raw[RAW_P1_LSB +: 5]  = p1_src;
    raw[RAW_P2_LSB +: 5]  = p2_src;
    raw[RAW_START1]       = pad_or[JOY_START1];
    raw[RAW_START2]       = pad_or[JOY_START2];
    raw[RAW_COIN]         = pad_or[JOY_COIN];
  end

  assign unused_hi = ^{io.joystick_0[15:8], io.joystick_1[15:8]};

  input_debounce #(
    .WIDTH    (RAW_W),
    .DEB_TICK (DEB_TICK)
  ) u_debounce (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .raw     (raw),
    .deb     (deb)
  );

  logic        vprev_q, vprev_d;
  logic        cprev_q, cprev_d;
  logic [9:0]  lat_q, lat_d;
  logic [1:0]  start_q, start_d;
  logic        vb_edge, coin_edge;

  always_comb begin
    vb_edge   = io.vblank & ~vprev_q;
    coin_edge = deb[RAW_COIN] & ~cprev_q;
    vprev_d   = io.vblank;
    cprev_d   = deb[RAW_COIN];
    start_d   = {deb[RAW_START2], deb[RAW_START1]};
    lat_d     = lat_q;
    if (vb_edge) begin
      lat_d = {socd_clean(deb[RAW_P2_LSB +: 5]), socd_clean(deb[RAW_P1_LSB +: 5])};
    end
  end

  coin_state_t state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d, fcnt_inc;
  logic        pending_q, pending_d;

  // Counter restarts at 0 on every state change; it only advances on vblank edges.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pending_d = pending_q;
    fcnt_inc  = fcnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (coin_edge) begin
          state_d = PULSE;
          fcnt_d  = 4'd0;
        end
      end
      PULSE: begin
        if (coin_edge) pending_d = 1'b1;
        if (vb_edge) begin
          if (fcnt_inc == CF) begin
            state_d = GAP;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      GAP: begin
        if (coin_edge) pending_d = 1'b1;
        if (vb_edge) begin
          if (fcnt_inc == CG) begin
            fcnt_d    = 4'd0;
            pending_d = 1'b0;
            state_d   = (pending_q || coin_edge) ? PULSE : IDLE;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        fcnt_d    = 4'd0;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vprev_q   <= 1'b0;
      cprev_q   <= 1'b0;
      lat_q     <= '0;
      start_q   <= '0;
      state_q   <= IDLE;
      fcnt_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      vprev_q   <= vprev_d;
      cprev_q   <= cprev_d;
      lat_q     <= lat_d;
      start_q   <= start_d;
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
    end
  end

  // coin1 decodes straight from the state flop so reset drops it immediately.
  assign io.coin1  = (state_q == PULSE);
  assign io.start1 = start_q[0];
  assign io.start2 = start_q[1];

  assign io.right1 = lat_q[RAW_P1_LSB + JOY_RIGHT];
  assign io.left1  = lat_q[RAW_P1_LSB + JOY_LEFT];
  assign io.down1  = lat_q[RAW_P1_LSB + JOY_DOWN];
  assign io.up1    = lat_q[RAW_P1_LSB + JOY_UP];
  assign io.fire1  = lat_q[RAW_P1_LSB + JOY_FIRE];
  assign io.right2 = lat_q[RAW_P2_LSB + JOY_RIGHT];
  assign io.left2  = lat_q[RAW_P2_LSB + JOY_LEFT];
  assign io.down2  = lat_q[RAW_P2_LSB + JOY_DOWN];
  assign io.up2    = lat_q[RAW_P2_LSB + JOY_UP];
  assign io.fire2  = lat_q[RAW_P2_LSB + JOY_FIRE];

  assign coin_state_dbg = state_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Self-checking bench: directed scenarios plus random pad traffic against a behavioural model.
module tb_arcade_input_cond;
  import arcade_input_pkg::*;

  localparam int DEB_TICK    = 8;
  localparam int COIN_FRAMES = 3;
  localparam int COIN_GAP    = 6;
  localparam int FRAME_LEN   = 40;
  localparam int VB_LEN      = 4;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  coin_state_t coin_state_dbg;

  arcade_input_cond_if io();

  arcade_input_cond #(
    .DEB_TICK    (DEB_TICK),
    .COIN_FRAMES (COIN_FRAMES),
    .COIN_GAP    (COIN_GAP)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .io             (io.slave),
    .coin_state_dbg (coin_state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];
  coin_state_t exp_state;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {io.coin1, io.start2, io.start1,
            io.fire2, io.up2, io.down2, io.left2, io.right2,
            io.fire1, io.up1, io.down1, io.left1, io.right1};
  endfunction

  // ---------------- reference model ----------------
  bit [12:0] m_samp, m_deb;
  bit [9:0]  m_lat;
  bit [1:0]  m_start;
  bit        m_vprev, m_cprev, m_vb_edge, m_queued;
  int        m_cyc, m_pulse_left, m_gap_left;
  int        pos;

  function automatic bit [4:0] clean(input bit [4:0] v);
    bit [4:0] r;
    r = v;
    if (v[3] && v[2]) begin r[3] = 1'b0; r[2] = 1'b0; end
    if (v[1] && v[0]) begin r[1] = 1'b0; r[0] = 1'b0; end
    return r;
  endfunction

  task automatic model_reset();
    m_samp = '0; m_deb = '0; m_lat = '0; m_start = '0;
    m_vprev = 1'b0; m_cprev = 1'b0; m_vb_edge = 1'b0; m_queued = 1'b0;
    m_cyc = 0; m_pulse_left = 0; m_gap_left = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [7:0]  por;
    bit [12:0] raw;
    bit        tick, cedge, gap_end;
    por       = io.joystick_0[7:0] | io.joystick_1[7:0];
    raw[4:0]  = io.cocktail ? io.joystick_0[4:0] : por[4:0];
    raw[9:5]  = io.cocktail ? io.joystick_1[4:0] : por[4:0];
    raw[10]   = por[5];
    raw[11]   = por[6];
    raw[12]   = por[7];
    tick      = (m_cyc == DEB_TICK - 1);
    m_vb_edge = io.vblank && !m_vprev;
    cedge     = m_deb[12] && !m_cprev;
    if (m_vb_edge) m_lat = {clean(m_deb[9:5]), clean(m_deb[4:0])};
    m_start = m_deb[11:10];
    m_vprev = io.vblank;
    m_cprev = m_deb[12];
    // coin: frames left high, then frames left low, at most one press queued
    if (m_pulse_left > 0) begin
      if (cedge) m_queued = 1'b1;
      if (m_vb_edge) begin
        m_pulse_left--;
        if (m_pulse_left == 0) m_gap_left = COIN_GAP;
      end
    end else if (m_gap_left > 0) begin
      gap_end = m_vb_edge && (m_gap_left == 1);
      if (gap_end) begin
        m_gap_left = 0;
        if (m_queued || cedge) m_pulse_left = COIN_FRAMES;
        m_queued = 1'b0;
      end else begin
        if (m_vb_edge) m_gap_left--;
        if (cedge) m_queued = 1'b1;
      end
    end else if (cedge) begin
      m_pulse_left = COIN_FRAMES;
    end
    if (tick) begin
      for (int i = 0; i < 13; i++) if (raw[i] == m_samp[i]) m_deb[i] = raw[i];
      m_samp = raw;
    end
    m_cyc = tick ? 0 : m_cyc + 1;
    exp_q.push_back({(m_pulse_left > 0), m_start, m_lat});
    exp_state = (m_pulse_left > 0) ? PULSE : (m_gap_left > 0) ? GAP : IDLE;
  endtask

  // ---------------- coin pulse tracker ----------------
  bit prev_c1, seen_fall;
  int cur_w, cur_gap, rises;
  int widths[$];
  int gaps[$];

  task automatic tracker_clear();
    prev_c1 = io.coin1; seen_fall = 1'b0;
    cur_w = 0; cur_gap = 0; rises = 0;
    widths.delete(); gaps.delete();
  endtask

  // ---------------- driver ----------------
  task automatic run_cycles(input int n);
    logic [12:0] e;
    bit c1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      io.vblank = (pos >= FRAME_LEN - VB_LEN);
      @(posedge clk_sys);
      if (reset_n) model_step();
      #1;
      if (reset_n) begin
        e = exp_q.pop_front();
        check_eq("outs", obs_vec(), e);
        check_eq("coin_state", coin_state_dbg, exp_state);
        c1 = io.coin1;
        if (m_vb_edge) begin
          if (prev_c1) cur_w++;
          else if (seen_fall) cur_gap++;
        end
        if (c1 && !prev_c1) begin
          rises++;
          if (seen_fall) gaps.push_back(cur_gap);
          cur_gap = 0;
        end
        if (!c1 && prev_c1) begin
          widths.push_back(cur_w);
          cur_w = 0;
          cur_gap = 0;
          seen_fall = 1'b1;
        end
        prev_c1 = c1;
      end
      pos = (pos + 1) % FRAME_LEN;
    end
  endtask

  task automatic press_coin(input int hold, input int rest);
    io.joystick_0 = 16'h0080;
    run_cycles(hold);
    io.joystick_0 = 16'h0000;
    run_cycles(rest);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wait_n;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    io.cocktail   = 1'b0;
    io.vblank     = 1'b0;
    reset_n       = 1'b0;
    model_reset();
    pos = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("reset_outs", obs_vec(), 13'h0);
    check_eq("reset_state", coin_state_dbg, IDLE);
    reset_n = 1'b1;
    tracker_clear();

    // shared pads: up on pad 1 reaches both players only at the vblank edge
    io.joystick_1 = 16'h0008;
    run_cycles(3 * DEB_TICK);
    check_eq("up1_before_vb", io.up1, 1'b0);
    check_eq("up2_before_vb", io.up2, 1'b0);
    run_cycles(FRAME_LEN - VB_LEN - 3 * DEB_TICK + 2);
    check_eq("up1_after_vb", io.up1, 1'b1);
    check_eq("up2_after_vb", io.up2, 1'b1);

    // cocktail: left+right on pad 0 cancel, fire on pad 1 goes to P2 only
    io.cocktail   = 1'b1;
    io.joystick_0 = 16'h0003;
    io.joystick_1 = 16'h0010;
    run_cycles(2 * FRAME_LEN);
    check_eq("socd_left1", io.left1, 1'b0);
    check_eq("socd_right1", io.right1, 1'b0);
    check_eq("cocktail_fire2", io.fire2, 1'b1);
    check_eq("cocktail_fire1", io.fire1, 1'b0);

    // short glitch on coin never produces a pulse
    io.cocktail   = 1'b0;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    run_cycles(2 * FRAME_LEN);
    tracker_clear();
    press_coin(DEB_TICK / 2, 3 * FRAME_LEN);
    check_eq("glitch_no_coin", rises, 0);

    // held coin: one pulse, COIN_FRAMES wide
    tracker_clear();
    press_coin(50 * FRAME_LEN, 10 * FRAME_LEN);
    check_eq("hold_rises", rises, 1);
    check_eq("hold_width", (widths.size() > 0) ? widths[0] : 0, COIN_FRAMES);

    // two presses two frames apart, third dropped while one is already queued
    tracker_clear();
    press_coin(3 * DEB_TICK, 2 * FRAME_LEN - 3 * DEB_TICK);
    press_coin(3 * DEB_TICK, 3 * FRAME_LEN - 3 * DEB_TICK);
    press_coin(3 * DEB_TICK, 20 * FRAME_LEN);
    check_eq("queue_rises", rises, 2);
    check_eq("queue_width0", (widths.size() > 0) ? widths[0] : 0, COIN_FRAMES);
    check_eq("queue_width1", (widths.size() > 1) ? widths[1] : 0, COIN_FRAMES);
    check_eq("queue_gap", (gaps.size() > 0) ? gaps[0] : 0, COIN_GAP);

    // reset in the middle of a pulse
    io.joystick_0 = 16'h0080;
    wait_n = 0;
    while (!io.coin1 && wait_n < 200) begin
      run_cycles(1);
      wait_n++;
    end
    check_eq("coin_rise_seen", io.coin1, 1'b1);
    run_cycles(2);
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("coin_async_rst", io.coin1, 1'b0);
    check_eq("state_async_rst", coin_state_dbg, IDLE);
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    model_reset();
    pos = 0;
    run_cycles(3 * FRAME_LEN);
    check_eq("post_rst_zero", obs_vec(), 13'h0);

    // random pad traffic
    tracker_clear();
    repeat (150) begin
      io.joystick_0 = 16'($urandom);
      io.joystick_1 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) io.joystick_0[7] = 1'b0;
      if ($urandom_range(0, 3) != 0) io.joystick_1[7] = 1'b0;
      io.cocktail = 1'($urandom_range(0, 1));
      run_cycles($urandom_range(1, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
